// File: rtl/psum_shift_accum.sv
// Shift-accumulates PE partial sums over bit-plane pairs and channel tiles into one signed dot product per pixel.
// Latency: result and o_Valid appear on the edge that takes the last sample; IDLE again one cycle later.
// Backpressure: none; i_Valid-low cycles in ACCUM stall all state, and no ready is returned upstream.
module psum_shift_accum #(
    parameter int BITS_PSUM = 10,
    parameter int BITS_ACC  = 32,
    parameter int BITS_PREC = 4,
    parameter int BITS_TILE = 8
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic                        i_Start,
    input  logic [BITS_PREC-1:0]        i_ActBits,
    input  logic [BITS_PREC-1:0]        i_WBits,
    input  logic [BITS_TILE-1:0]        i_NumTiles,
    input  logic                        i_Valid,
    input  logic signed [BITS_PSUM-1:0] i_PSUM,
    output logic                        o_Busy,
    output logic                        o_Valid,
    output logic signed [BITS_ACC-1:0]  o_Result,
    output logic                        o_Overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state, state_nxt;

    logic [2:0]                 a_cnt, w_cnt, a_max, w_max;
    logic [BITS_TILE-1:0]       t_cnt, t_max;
    logic signed [BITS_ACC-1:0] acc;
    logic signed [BITS_ACC-1:0] psum_ext, addend;
    logic [3:0]                 shift;
    logic [BITS_ACC:0]          sum_wide;
    logic                       take, last, start;

    // Precision field -> max counter value; 0 behaves as 1, anything above 8 as 8.
    function automatic logic [2:0] prec_max(input logic [BITS_PREC-1:0] p);
        int unsigned pv;
        pv = 32'(p);
        if (pv == 0)
            return 3'd0;
        else if (pv > 8)
            return 3'd7;
        else
            return 3'(pv - 1);
    endfunction

    assign start    = (state == IDLE) && i_Start;
    assign take     = (state == ACCUM) && i_Valid;
    assign last     = take && (a_cnt == a_max) && (w_cnt == w_max) && (t_cnt == t_max);
    assign shift    = {1'b0, a_cnt} + {1'b0, w_cnt};
    assign psum_ext = {{(BITS_ACC-BITS_PSUM){i_PSUM[BITS_PSUM-1]}}, i_PSUM};
    assign addend   = psum_ext <<< shift;
    // One extra bit so a signed overflow shows up as differing top two bits.
    assign sum_wide = {acc[BITS_ACC-1], acc} + {addend[BITS_ACC-1], addend};

    always_ff @(posedge CLK) begin
        if (!RSTN)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_Busy    = 1'b0;
        o_Valid   = 1'b0;
        case (state)
            IDLE:  if (i_Start) state_nxt = ACCUM;
            ACCUM: begin
                o_Busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                o_Valid   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            a_cnt      <= '0;
            w_cnt      <= '0;
            t_cnt      <= '0;
            a_max      <= '0;
            w_max      <= '0;
            t_max      <= '0;
            acc        <= '0;
            o_Result   <= '0;
            o_Overflow <= 1'b0;
        end else if (start) begin
            a_max      <= prec_max(i_ActBits);
            w_max      <= prec_max(i_WBits);
            t_max      <= i_NumTiles;
            a_cnt      <= '0;
            w_cnt      <= '0;
            t_cnt      <= '0;
            acc        <= '0;
            o_Overflow <= 1'b0;
        end else if (take) begin
            acc <= sum_wide[BITS_ACC-1:0];
            if (sum_wide[BITS_ACC] != sum_wide[BITS_ACC-1])
                o_Overflow <= 1'b1;
            if (last)
                o_Result <= sum_wide[BITS_ACC-1:0];
            if (a_cnt == a_max) begin
                a_cnt <= '0;
                if (w_cnt == w_max) begin
                    w_cnt <= '0;
                    t_cnt <= (t_cnt == t_max) ? '0 : t_cnt + 1'b1;
                end else begin
                    w_cnt <= w_cnt + 1'b1;
                end
            end else begin
                a_cnt <= a_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psum_shift_accum.sv
// Directed bench for psum_shift_accum: scoreboard of expected pixel results checked on every o_Valid pulse.
module tb_psum_shift_accum;

    localparam int PW = 10;
    localparam int AW = 24;
    localparam int PR = 4;
    localparam int TW = 8;
    localparam longint MAXV = (longint'(1) <<< (AW-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (AW-1));

    logic                 CLK = 1'b0;
    logic                 RSTN = 1'b0;
    logic                 i_Start = 1'b0;
    logic [PR-1:0]        i_ActBits = '0;
    logic [PR-1:0]        i_WBits = '0;
    logic [TW-1:0]        i_NumTiles = '0;
    logic                 i_Valid = 1'b0;
    logic signed [PW-1:0] i_PSUM = '0;
    logic                 o_Busy, o_Valid, o_Overflow;
    logic signed [AW-1:0] o_Result;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    longint exp_res_q[$];
    logic   exp_ovf_q[$];

    always #5 CLK = ~CLK;

    psum_shift_accum #(
        .BITS_PSUM(PW), .BITS_ACC(AW), .BITS_PREC(PR), .BITS_TILE(TW)
    ) dut (
        .CLK(CLK), .RSTN(RSTN), .i_Start(i_Start), .i_ActBits(i_ActBits),
        .i_WBits(i_WBits), .i_NumTiles(i_NumTiles), .i_Valid(i_Valid),
        .i_PSUM(i_PSUM), .o_Busy(o_Busy), .o_Valid(o_Valid),
        .o_Result(o_Result), .o_Overflow(o_Overflow)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then look at outputs; any o_Valid is scored against the queue.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (o_Valid) begin
            valid_cnt++;
            if (exp_res_q.size() == 0)
                chk("spurious_valid", longint'(o_Valid), 0);
            else begin
                chk("result", o_Result, exp_res_q.pop_front());
                chk("overflow", longint'(o_Overflow), longint'(exp_ovf_q.pop_front()));
            end
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        logic signed [AW-1:0] t;
        t = v[AW-1:0];
        return t;
    endfunction

    function automatic int psum_of(input int mode, input int val, input int idx);
        return (mode == 0) ? val : idx + 1;
    endfunction

    task automatic run_pixel(input int ab, input int wb, input int nt, input int mode,
                             input int val, input int stall, input bit mid_start,
                             input bit valid_with_start);
        int ea, ew, idx, total, v0;
        longint acc_m, s, add;
        bit ovf;
        ea = (ab == 0) ? 1 : ((ab > 8) ? 8 : ab);
        ew = (wb == 0) ? 1 : ((wb > 8) ? 8 : wb);
        acc_m = 0;
        ovf = 1'b0;
        idx = 0;
        for (int t = 0; t <= nt; t++)
            for (int w = 0; w < ew; w++)
                for (int a = 0; a < ea; a++) begin
                    add = longint'(psum_of(mode, val, idx)) * (longint'(1) <<< (a + w));
                    s = acc_m + add;
                    if (s > MAXV || s < MINV) ovf = 1'b1;
                    acc_m = wrap_acc(s);
                    idx++;
                end
        exp_res_q.push_back(acc_m);
        exp_ovf_q.push_back(ovf);
        total = idx;

        i_ActBits  = PR'(ab);
        i_WBits    = PR'(wb);
        i_NumTiles = TW'(nt);
        i_Start    = 1'b1;
        if (valid_with_start) begin
            i_Valid = 1'b1;
            i_PSUM  = PW'(100);
        end
        tick();
        i_Start = 1'b0;
        i_Valid = 1'b0;
        chk("busy_after_start", longint'(o_Busy), 1);
        chk("ovf_clear_on_start", longint'(o_Overflow), 0);
        v0 = valid_cnt;
        for (int n = 0; n < total; n++) begin
            i_PSUM  = PW'(psum_of(mode, val, n));
            i_Valid = 1'b1;
            tick();
            i_Valid = 1'b0;
            if (n < total - 1) begin
                chk("busy_in_accum", longint'(o_Busy), 1);
                for (int k = 0; k < stall; k++) begin
                    if (mid_start) begin
                        i_Start    = 1'b1;
                        i_ActBits  = PR'(1);
                        i_WBits    = PR'(1);
                        i_NumTiles = '0;
                    end
                    tick();
                    i_Start = 1'b0;
                    chk("busy_stall", longint'(o_Busy), 1);
                end
            end else begin
                chk("busy_fall", longint'(o_Busy), 0);
                chk("valid_on_last", valid_cnt, v0 + 1);
            end
        end
        tick();
        chk("valid_one_cycle", valid_cnt, v0 + 1);
        chk("idle_not_busy", longint'(o_Busy), 0);
    endtask

    initial begin
        int v;
        RSTN = 1'b0;
        for (int r = 0; r < 2; r++) begin
            i_Start    = 1'($urandom);
            i_Valid    = 1'($urandom);
            i_ActBits  = PR'($urandom);
            i_WBits    = PR'($urandom);
            i_NumTiles = TW'($urandom);
            i_PSUM     = PW'($urandom);
            tick();
            chk("rst_valid", longint'(o_Valid), 0);
            chk("rst_busy", longint'(o_Busy), 0);
            chk("rst_overflow", longint'(o_Overflow), 0);
            chk("rst_result", o_Result, 0);
        end
        i_Start = 1'b0;
        i_Valid = 1'b0;
        RSTN    = 1'b1;
        for (int r = 0; r < 3; r++) begin
            i_Valid = 1'b1;
            i_PSUM  = PW'(r + 1);
            tick();
        end
        i_Valid = 1'b0;
        tick();
        chk("no_valid_without_start", valid_cnt, 0);
        chk("idle_after_reset", longint'(o_Busy), 0);

        run_pixel(1, 1, 0, 0, -5, 0, 1'b0, 1'b1);
        run_pixel(2, 2, 1, 1, 0, 0, 1'b0, 1'b0);
        run_pixel(2, 2, 1, 1, 0, 3, 1'b0, 1'b0);
        run_pixel(2, 2, 1, 1, 0, 3, 1'b1, 1'b0);
        run_pixel(0, 9, 0, 1, 0, 0, 1'b0, 1'b0);
        run_pixel(8, 8, 255, 0, -512, 0, 1'b0, 1'b0);
        run_pixel(1, 1, 0, 0, 3, 0, 1'b0, 1'b0);

        // Abort a pixel with reset after three samples.
        i_ActBits  = PR'(2);
        i_WBits    = PR'(2);
        i_NumTiles = TW'(1);
        i_Start    = 1'b1;
        tick();
        i_Start = 1'b0;
        for (int r = 0; r < 3; r++) begin
            i_Valid = 1'b1;
            i_PSUM  = PW'(50);
            tick();
        end
        i_Valid = 1'b0;
        RSTN    = 1'b0;
        tick();
        RSTN = 1'b1;
        chk("abort_not_busy", longint'(o_Busy), 0);
        chk("abort_result_cleared", o_Result, 0);
        v = valid_cnt;
        tick();
        tick();
        chk("abort_no_valid", valid_cnt, v);
        run_pixel(1, 1, 0, 0, 7, 0, 1'b0, 1'b0);

        chk("all_results_seen", exp_res_q.size(), 0);
        chk("total_valids", valid_cnt, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
